// File: rtl/eventually_monitor.sv
// Checks that a holds within [MIN_DELAY, MAX_DELAY] cycles after each start, tracking up to SLOTS concurrent attempts.
// Verdict pulses and counters are registered, so they appear one cycle after resolution. There is no backpressure; a start with no free slot is dropped and flagged.
module eventually_monitor #(
    parameter int MIN_DELAY = 2,
    parameter int MAX_DELAY = 5,
    parameter int UNBOUNDED = 0,
    parameter int STRONG    = 1,
    parameter int SLOTS     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        a,
    input  logic        end_of_trace,
    output logic        pass,
    output logic        fail,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [3:0]  pending,
    output logic        overflow,
    output logic        cfg_err
);

    localparam logic [7:0] MIN_K   = 8'(MIN_DELAY);
    localparam logic [7:0] MAX_K   = 8'(MAX_DELAY);
    localparam bit         BOUNDED = (UNBOUNDED == 0);
    localparam bit         WEAK    = (STRONG == 0);
    localparam bit         CFG_BAD = (UNBOUNDED != 0) && (STRONG == 0);

    logic [SLOTS-1:0] act_q, act_d;
    logic [7:0]       age_q [SLOTS];
    logic [7:0]       age_d [SLOTS];
    logic             pass_q, pass_d, fail_q, fail_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      pcnt_q, pcnt_d, fcnt_q, fcnt_d;
    logic [3:0]       pend_q, pend_d;

    logic             free_found;
    logic [2:0]       free_idx;
    logic             take, drop;

    logic [SLOTS-1:0] slot_v, slot_p, slot_f, slot_rem;
    logic [SLOTS-1:0] res_p, res_f;
    logic [7:0]       slot_k [SLOTS];
    logic [3:0]       npass, nfail;
    logic [16:0]      psum, fsum;

    // Only slots idle at the start of the cycle are eligible, so a slot freed now is reused next cycle at the earliest.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!act_q[s]) begin
                free_found = 1'b1;
                free_idx   = 3'(s);
            end
        end
        take = start && !CFG_BAD && free_found;
        drop = start && !CFG_BAD && !free_found;
    end

    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            slot_v[s]   = act_q[s] || (take && free_idx == 3'(s));
            slot_k[s]   = act_q[s] ? age_q[s] : 8'd0;
            slot_p[s]   = slot_v[s] && a && (slot_k[s] >= MIN_K)
                          && (!BOUNDED || slot_k[s] <= MAX_K);
            slot_f[s]   = slot_v[s] && !slot_p[s] && BOUNDED && (slot_k[s] == MAX_K);
            slot_rem[s] = slot_v[s] && !slot_p[s] && !slot_f[s];
            res_p[s]    = slot_p[s] || (end_of_trace && slot_rem[s] && WEAK);
            res_f[s]    = slot_f[s] || (end_of_trace && slot_rem[s] && !WEAK);
            act_d[s]    = slot_rem[s] && !end_of_trace;
            age_d[s]    = 8'd0;
            if (act_d[s]) begin
                // An unbounded attempt parks its age at MIN_DELAY; only the lower bound matters from there on.
                age_d[s] = (!BOUNDED && slot_k[s] >= MIN_K) ? slot_k[s] : slot_k[s] + 8'd1;
            end
        end
    end

    always_comb begin
        npass  = '0;
        nfail  = '0;
        pend_d = '0;
        for (int s = 0; s < SLOTS; s++) begin
            npass  = npass + 4'(res_p[s]);
            nfail  = nfail + 4'(res_f[s]);
            pend_d = pend_d + 4'(act_d[s]);
        end
        pass_d = |res_p;
        fail_d = |res_f;
        ovf_d  = ovf_q || drop;
        psum   = {1'b0, pcnt_q} + 17'(npass);
        fsum   = {1'b0, fcnt_q} + 17'(nfail);
        pcnt_d = psum[16] ? 16'hFFFF : psum[15:0];
        fcnt_d = fsum[16] ? 16'hFFFF : fsum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            ovf_q  <= 1'b0;
            pcnt_q <= '0;
            fcnt_q <= '0;
            pend_q <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                age_q[s] <= '0;
            end
        end else begin
            act_q  <= act_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            ovf_q  <= ovf_d;
            pcnt_q <= pcnt_d;
            fcnt_q <= fcnt_d;
            pend_q <= pend_d;
            for (int s = 0; s < SLOTS; s++) begin
                age_q[s] <= age_d[s];
            end
        end
    end

    assign pass     = pass_q;
    assign fail     = fail_q;
    assign pass_cnt = pcnt_q;
    assign fail_cnt = fcnt_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;
    assign cfg_err  = CFG_BAD;

endmodule

// File: tb/tb_eventually_monitor.sv
// Four monitor variants (default, weak, unbounded, illegal weak unbounded) with a per-instance verdict scoreboard.
module tb_eventually_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a, eot;
    logic [3:0]  start_v;
    logic        pass_w [4];
    logic        fail_w [4];
    logic        ovf_w  [4];
    logic        cerr_w [4];
    logic [15:0] pc_w   [4];
    logic [15:0] fc_w   [4];
    logic [3:0]  pend_w [4];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int t0;

    typedef struct {
        int          cyc;
        logic        p;
        logic        f;
        logic [15:0] pc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb [4][$];
    exp_t e;

    eventually_monitor u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .end_of_trace(eot),
        .pass(pass_w[0]), .fail(fail_w[0]), .pass_cnt(pc_w[0]), .fail_cnt(fc_w[0]),
        .pending(pend_w[0]), .overflow(ovf_w[0]), .cfg_err(cerr_w[0])
    );
    eventually_monitor #(.STRONG(0)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .end_of_trace(eot),
        .pass(pass_w[1]), .fail(fail_w[1]), .pass_cnt(pc_w[1]), .fail_cnt(fc_w[1]),
        .pending(pend_w[1]), .overflow(ovf_w[1]), .cfg_err(cerr_w[1])
    );
    eventually_monitor #(.UNBOUNDED(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .end_of_trace(eot),
        .pass(pass_w[2]), .fail(fail_w[2]), .pass_cnt(pc_w[2]), .fail_cnt(fc_w[2]),
        .pending(pend_w[2]), .overflow(ovf_w[2]), .cfg_err(cerr_w[2])
    );
    eventually_monitor #(.UNBOUNDED(1), .STRONG(0)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a), .end_of_trace(eot),
        .pass(pass_w[3]), .fail(fail_w[3]), .pass_cnt(pc_w[3]), .fail_cnt(fc_w[3]),
        .pending(pend_w[3]), .overflow(ovf_w[3]), .cfg_err(cerr_w[3])
    );

    // Monitor: every verdict pulse must match the next queued expectation for that instance.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pass_w[i] === 1'b1 || fail_w[i] === 1'b1) begin
                total++;
                if (sb[i].size() == 0) begin
                    bad++;
                    $display("FAIL verdict_unexpected inst%0d cyc=%0d got pass=%0b fail=%0b required no verdict",
                             i, cyc, pass_w[i], fail_w[i]);
                end else begin
                    e = sb[i].pop_front();
                    if (cyc != e.cyc || pass_w[i] !== e.p || fail_w[i] !== e.f ||
                        pc_w[i] !== e.pc || fc_w[i] !== e.fc) begin
                        bad++;
                        $display("FAIL verdict inst%0d got cyc=%0d p=%0b f=%0b pc=%0d fc=%0d required cyc=%0d p=%0b f=%0b pc=%0d fc=%0d",
                                 i, cyc, pass_w[i], fail_w[i], pc_w[i], fc_w[i],
                                 e.cyc, e.p, e.f, e.pc, e.fc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push(input int i, input int c, input logic p, input logic f,
                        input logic [15:0] pc, input logic [15:0] fc);
        exp_t x;
        x.cyc = c; x.p = p; x.f = f; x.pc = pc; x.fc = fc;
        sb[i].push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1; start_v = '0; a = 1'b0; eot = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        rst = 1'b1; start_v = '0; a = 1'b0; eot = 1'b0;

        // Reset state and configuration flag
        do_reset();
        chk("rst_pass", int'(pass_w[0]), 0);
        chk("rst_fail", int'(fail_w[0]), 0);
        chk("rst_pass_cnt", int'(pc_w[0]), 0);
        chk("rst_fail_cnt", int'(fc_w[0]), 0);
        chk("rst_pending", int'(pend_w[0]), 0);
        chk("rst_overflow", int'(ovf_w[0]), 0);
        chk("cfg_err_default", int'(cerr_w[0]), 0);
        chk("cfg_err_unbounded_strong", int'(cerr_w[2]), 0);
        chk("cfg_err_unbounded_weak", int'(cerr_w[3]), 1);

        // a=1 only at cycle 3 -> pass at cycle 4
        start_v[0] = 1'b1; tick();
        start_v[0] = 1'b0; tick();
        tick();
        chk("t1_pending_c3", int'(pend_w[0]), 1);
        a = 1'b1; push(0, t0 + 4, 1'b1, 1'b0, 16'd1, 16'd0); tick();
        a = 1'b0;
        chk("t1_pending_c4", int'(pend_w[0]), 0);
        chk("t1_pass_cnt_c4", int'(pc_w[0]), 1);
        repeat (6) tick();

        // a=1 only at cycle 1 (too early) -> fail at cycle 6
        do_reset();
        start_v[0] = 1'b1; tick();
        start_v[0] = 1'b0; a = 1'b1; tick();
        a = 1'b0; push(0, t0 + 6, 1'b0, 1'b1, 16'd0, 16'd1);
        repeat (8) tick();

        // starts at 0..4, a=0 -> slots full, overflow, four fails
        do_reset();
        start_v[0] = 1'b1;
        repeat (4) tick();
        chk("t3_pending_c4", int'(pend_w[0]), 4);
        chk("t3_overflow_c4", int'(ovf_w[0]), 0);
        tick();
        start_v[0] = 1'b0;
        chk("t3_overflow_c5", int'(ovf_w[0]), 1);
        for (int n = 0; n < 4; n++) push(0, t0 + 6 + n, 1'b0, 1'b1, 16'd0, 16'(n + 1));
        repeat (6) tick();
        chk("t3_pending_end", int'(pend_w[0]), 0);
        chk("t3_overflow_sticky", int'(ovf_w[0]), 1);

        // end_of_trace with two open attempts: strong fails, weak passes
        do_reset();
        start_v = 4'b0011; tick();
        tick();
        start_v = 4'b0000; tick();
        eot = 1'b1;
        push(0, t0 + 4, 1'b0, 1'b1, 16'd0, 16'd2);
        push(1, t0 + 4, 1'b1, 1'b0, 16'd2, 16'd0);
        tick();
        eot = 1'b0;
        repeat (3) tick();

        // Unbounded: early a ignored, late a passes; illegal form stays silent
        do_reset();
        start_v = 4'b1100; tick();
        start_v = 4'b0000; a = 1'b1; tick();
        a = 1'b0;
        repeat (48) tick();
        chk("t5_pending_c50", int'(pend_w[2]), 1);
        chk("t5_cfg_pending", int'(pend_w[3]), 0);
        a = 1'b1; push(2, t0 + 51, 1'b1, 1'b0, 16'd1, 16'd0); tick();
        a = 1'b0; start_v[2] = 1'b1; tick();
        start_v[2] = 1'b0; tick();
        tick();
        tick();
        eot = 1'b1; push(2, t0 + 56, 1'b0, 1'b1, 16'd1, 16'd1); tick();
        eot = 1'b0;
        repeat (3) tick();
        chk("t5_cfg_pass_cnt", int'(pc_w[3]), 0);
        chk("t5_cfg_fail_cnt", int'(fc_w[3]), 0);

        // Reset mid-attempt abandons it without verdict
        do_reset();
        start_v[0] = 1'b1; tick();
        tick();
        start_v[0] = 1'b0; a = 1'b1; push(0, t0 + 3, 1'b1, 1'b0, 16'd1, 16'd0); tick();
        a = 1'b0;
        chk("t6_pending_c3", int'(pend_w[0]), 1);
        rst = 1'b1; tick();
        rst = 1'b0; a = 1'b1;
        chk("t6_pending_c4", int'(pend_w[0]), 0);
        chk("t6_pass_cnt_c4", int'(pc_w[0]), 0);
        chk("t6_pass_c4", int'(pass_w[0]), 0);
        tick();
        a = 1'b0;
        repeat (8) tick();

        // a=1 exactly at MAX_DELAY passes
        do_reset();
        start_v[0] = 1'b1; tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        a = 1'b1; push(0, t0 + 6, 1'b1, 1'b0, 16'd1, 16'd0); tick();
        a = 1'b0;
        repeat (3) tick();

        // Start coincident with end_of_trace: old attempt passes, new one fails, both pulse together
        do_reset();
        start_v[0] = 1'b1; tick();
        start_v[0] = 1'b0; tick();
        tick();
        start_v[0] = 1'b1; a = 1'b1; eot = 1'b1;
        push(0, t0 + 4, 1'b1, 1'b1, 16'd1, 16'd1);
        tick();
        start_v[0] = 1'b0; a = 1'b0; eot = 1'b0;
        chk("t8_pending_c4", int'(pend_w[0]), 0);
        repeat (3) tick();

        for (int i = 0; i < 4; i++) chk($sformatf("sb_drained_inst%0d", i), sb[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eventually_monitor.md
EVENTUALLY_MONITOR -- requirements
Module: eventually_monitor

Interface
REQ-001 SHALL have parameter MIN_DELAY, default 2, lower window bound in cycles (0..255).
REQ-002 SHALL have parameter MAX_DELAY, default 5, upper window bound in cycles (>= MIN_DELAY, <= 255); ignored when UNBOUNDED=1.
REQ-003 SHALL have parameter UNBOUNDED, default 0, 1 = upper bound is $.
REQ-004 SHALL have parameter STRONG, default 1, 1 = s_eventually, 0 = eventually (weak).
REQ-005 SHALL have parameter SLOTS, default 4, max concurrent attempts (1..8).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, launches a new attempt at the current cycle.
REQ-009 SHALL have port a, input, 1, operand expression sampled each cycle.
REQ-010 SHALL have port end_of_trace, input, 1, one-cycle pulse marking end of simulation trace.
REQ-011 SHALL have port pass, output, 1, one-cycle pulse: at least one attempt passed.
REQ-012 SHALL have port fail, output, 1, one-cycle pulse: at least one attempt failed.
REQ-013 SHALL have port pass_cnt, output, 16, total passed attempts, saturating.
REQ-014 SHALL have port fail_cnt, output, 16, total failed attempts, saturating.
REQ-015 SHALL have port pending, output, 4, number of active slots.
REQ-016 SHALL have port overflow, output, 1, sticky: a start was dropped.
REQ-017 SHALL have port cfg_err, output, 1, constant 1 when UNBOUNDED=1 and STRONG=0 (illegal weak unbounded form); otherwise 0.

Function
REQ-018 Each slot SHALL hold an active bit and an 8-bit age k; a new attempt SHALL be given k=0 in its start cycle and k SHALL increment once per cycle thereafter.
REQ-019 When UNBOUNDED=1, k SHALL stop incrementing once k = MIN_DELAY.
REQ-020 Slot allocation SHALL pick the lowest-index slot inactive at the start of the cycle; a slot freed in a cycle SHALL NOT be reused in that same cycle.
REQ-021 start with no free slot SHALL drop the attempt and set overflow until reset.
REQ-022 An active slot (including one starting this cycle) with k >= MIN_DELAY and k <= MAX_DELAY (or unbounded) and a=1 SHALL resolve as pass and free.
REQ-023 An active slot with k = MAX_DELAY and a=0 (bounded only) SHALL resolve as fail and free, regardless of STRONG.
REQ-024 end_of_trace SHALL resolve every slot still unresolved after REQ-022/023 in that cycle: fail when STRONG=1, pass when STRONG=0; all slots free.
REQ-025 A start coincident with end_of_trace SHALL be evaluated per REQ-022 first, then REQ-024.
REQ-026 pass/fail SHALL be registered: asserted in the cycle after resolution, exactly one cycle, ORed over slots; both may assert together.
REQ-027 pass_cnt/fail_cnt SHALL add the number of slots resolved in a cycle (registered, same cycle as the pulse) and saturate at 16'hFFFF.
REQ-028 pending SHALL equal the registered count of active slots.
REQ-029 When cfg_err=1, start SHALL be ignored and pass/fail SHALL stay 0.

Reset
REQ-030 rst=1 SHALL clear all slots, pass, fail, pass_cnt, fail_cnt, pending and overflow to 0 on the next edge, abandoning in-flight attempts without any verdict; rst has priority over all inputs.

Verification (defaults unless stated; start at cycle 0)
REQ-031 a=1 only at cycle 3 -> pass=1 at cycle 4, pass_cnt=1, pending back to 0 at cycle 4.
REQ-032 a=1 only at cycle 1 -> no pass; fail=1 at cycle 6, fail_cnt=1.
REQ-033 start at cycles 0..4, a=0 -> pending=4 at cycle 4, overflow=1 at cycle 5; fails at cycles 6..9, fail_cnt=4.
REQ-034 starts at cycles 0,1, end_of_trace at cycle 3, a=0 -> fail_cnt=2 at cycle 4; with STRONG=0 -> pass_cnt=2 instead.
REQ-035 UNBOUNDED=1: a=1 at cycle 1 ignored, a=1 at cycle 50 -> pass at cycle 51; UNBOUNDED=1, STRONG=0 -> cfg_err=1, no verdicts.
REQ-036 rst at cycle 3 of an attempt -> all outputs 0 at cycle 4; a=1 at cycle 4 produces no pass.
